// File: rtl/hack_pkg.sv
// Shared Hack-platform definitions used by the CPU, ALU, RAM and PC blocks.
//   WORD_WIDTH : native data/address word width
//   WORD_ZERO  : all-zero word, the reset/clear value
package hack_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam logic [WORD_WIDTH-1:0] WORD_ZERO = '0;

endpackage : hack_pkg

// File: rtl/word_register.sv
// WIDTH-bit register built from WIDTH independent Bit cells sharing one load.
// The cells carry no reset or initialiser; clearing is done by the caller.
//   clk  : rising-edge clock
//   load : write enable common to every Bit cell
//   in   : word to capture when load=1
//   out  : stored word (straight from the cells)
module word_register
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] bits;

  // One Bit cell per position: hold unless load is asserted.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    always_ff @(posedge clk) begin
      if (load) begin
        bits[g] <= in[g];
      end
    end
  end

  assign out = bits;

endmodule : word_register

// File: rtl/program_counter.sv
// Hack program counter: hold / increment / load / clear, one-cycle latency.
// Priority at each rising edge: reset > load > inc > hold.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   in    : jump target, captured when load=1 and reset=0
//   load  : load in on the next edge
//   inc   : increment on the next edge (mod 2^WIDTH)
//   out   : current counter value, registered
module program_counter
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] ZERO = WIDTH'(WORD_ZERO);

  if (WIDTH < 2) begin : g_width_check
    $error("program_counter: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] inc_mux;
  logic [WIDTH-1:0] load_mux;
  logic [WIDTH-1:0] next_val;
  logic             carry;

  // Half-adder ripple: add one, final carry discarded so the count wraps.
  always_comb begin
    inc_val = '0;
    carry   = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      inc_val[i] = out[i] ^ carry;
      carry      = carry & out[i];
    end
  end

  // Three 2:1 word muxes; the outermost (reset) has the highest priority.
  always_comb begin
    inc_mux  = inc   ? inc_val : out;
    load_mux = load  ? in      : inc_mux;
    next_val = reset ? ZERO    : load_mux;
  end

  // State register is written every cycle; the mux chain decides what.
  word_register #(
    .WIDTH (WIDTH)
  ) u_state (
    .clk  (clk),
    .load (1'b1),
    .in   (next_val),
    .out  (out)
  );

endmodule : program_counter
